// File: rtl/exme_reg.sv
// EX/MEM pipeline register with a memory-handshake stall FSM.
// A valid memory instruction raises ExMe_out_mem_en for its first cycle only.
// The register then freezes until mem_done, while stall holds the upstream stages.
module exme_reg (
  input  logic        clk,
  input  logic        rst_n,   // active-high asynchronous reset, despite the name
  input  logic [31:0] Ex_alu_out,
  input  logic [31:0] Ex_reg_2,
  input  logic        Ex_mem_wrt,
  input  logic        Ex_mem_en,
  input  logic        Ex_reg_wrt,
  input  logic        Ex_mem_to_reg,
  input  logic [4:0]  Ex_rd,
  input  logic        Ex_valid,
  input  logic        flush,
  input  logic        mem_done,
  output logic [31:0] ExMe_out_alu_out,
  output logic [31:0] ExMe_out_reg_2,
  output logic        ExMe_out_mem_wrt,
  output logic        ExMe_out_reg_wrt,
  output logic        ExMe_out_mem_to_reg,
  output logic [4:0]  ExMe_out_rd,
  output logic        ExMe_out_valid,
  output logic        ExMe_out_mem_en,
  output logic        stall,
  output logic [15:0] stall_cnt
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t state;
  logic   liveIn;

  // A bubble is loaded when the execute stage is empty or being flushed.
  assign liveIn = Ex_valid & ~flush;

  // Stall while a request is outstanding (its first cycle or WAIT) and not yet done.
  assign stall = (ExMe_out_mem_en | (state == WAIT)) & ~mem_done;

  // Pipeline register: load on every unstalled edge, hold while stalled.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ExMe_out_alu_out    <= '0;
      ExMe_out_reg_2      <= '0;
      ExMe_out_mem_wrt    <= 1'b0;
      ExMe_out_reg_wrt    <= 1'b0;
      ExMe_out_mem_to_reg <= 1'b0;
      ExMe_out_rd         <= '0;
      ExMe_out_valid      <= 1'b0;
    end else if (!stall) begin
      ExMe_out_alu_out    <= liveIn ? Ex_alu_out : 32'd0;
      ExMe_out_reg_2      <= liveIn ? Ex_reg_2   : 32'd0;
      ExMe_out_mem_wrt    <= liveIn & Ex_mem_wrt;
      ExMe_out_reg_wrt    <= liveIn & Ex_reg_wrt;
      ExMe_out_mem_to_reg <= liveIn & Ex_mem_to_reg;
      ExMe_out_rd         <= liveIn ? Ex_rd : 5'd0;
      ExMe_out_valid      <= liveIn;
    end
  end

  // Handshake FSM; mem_en is a registered one-cycle request pulse.
  // A stalled edge always leaves the first cycle, so the pulse clears there;
  // an unstalled edge loads the next instruction's request with no dead cycle.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state           <= IDLE;
      ExMe_out_mem_en <= 1'b0;
    end else begin
      ExMe_out_mem_en <= stall ? 1'b0 : (liveIn & Ex_mem_en);
      case (state)
        IDLE:    if (ExMe_out_mem_en && !mem_done) state <= WAIT;
        WAIT:    if (mem_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of stalled edges.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      stall_cnt <= '0;
    else if (stall && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_exme_reg.sv
// Directed bench for exme_reg: pass-through, multi-cycle load, zero-wait
// store, back-to-back requests, flush/hold, spurious done, reset, saturation.
module tb_exme_reg;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Ex_alu_out, Ex_reg_2;
  logic        Ex_mem_wrt, Ex_mem_en, Ex_reg_wrt, Ex_mem_to_reg;
  logic [4:0]  Ex_rd;
  logic        Ex_valid, flush, mem_done;
  logic [31:0] ExMe_out_alu_out, ExMe_out_reg_2;
  logic        ExMe_out_mem_wrt, ExMe_out_reg_wrt, ExMe_out_mem_to_reg;
  logic [4:0]  ExMe_out_rd;
  logic        ExMe_out_valid, ExMe_out_mem_en, stall;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  exme_reg dut (
    .clk(clk), .rst_n(rst_n),
    .Ex_alu_out(Ex_alu_out), .Ex_reg_2(Ex_reg_2),
    .Ex_mem_wrt(Ex_mem_wrt), .Ex_mem_en(Ex_mem_en),
    .Ex_reg_wrt(Ex_reg_wrt), .Ex_mem_to_reg(Ex_mem_to_reg),
    .Ex_rd(Ex_rd), .Ex_valid(Ex_valid), .flush(flush), .mem_done(mem_done),
    .ExMe_out_alu_out(ExMe_out_alu_out), .ExMe_out_reg_2(ExMe_out_reg_2),
    .ExMe_out_mem_wrt(ExMe_out_mem_wrt), .ExMe_out_reg_wrt(ExMe_out_reg_wrt),
    .ExMe_out_mem_to_reg(ExMe_out_mem_to_reg), .ExMe_out_rd(ExMe_out_rd),
    .ExMe_out_valid(ExMe_out_valid), .ExMe_out_mem_en(ExMe_out_mem_en),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setEx(input logic [31:0] alu, input logic [31:0] r2, input logic wrt,
                       input logic en, input logic rw, input logic m2r,
                       input logic [4:0] rd, input logic v);
    Ex_alu_out = alu; Ex_reg_2 = r2; Ex_mem_wrt = wrt; Ex_mem_en = en;
    Ex_reg_wrt = rw; Ex_mem_to_reg = m2r; Ex_rd = rd; Ex_valid = v;
  endtask

  // Every output must be zero.
  task automatic chkAllZero(input string tag);
    chk({tag, ".alu"}, ExMe_out_alu_out, 32'd0);
    chk({tag, ".ctl"}, {ExMe_out_reg_2 != 0, ExMe_out_mem_wrt, ExMe_out_reg_wrt,
                        ExMe_out_mem_to_reg, ExMe_out_rd != 0, ExMe_out_valid,
                        ExMe_out_mem_en, stall}, 32'd0);
    chk({tag, ".cnt"}, stall_cnt, 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; mem_done = 1'b0;
    setEx(32'hAAAA_5555, 32'h1111_2222, 1, 1, 1, 1, 5'd31, 1);
    repeat (3) step();
    chkAllZero("reset");
    rst_n = 1'b0;

    // ALU pass-through
    setEx(32'h0000_1234, 32'h0, 0, 0, 1, 0, 5'd5, 1);
    step();
    chk("alu.out", ExMe_out_alu_out, 32'h0000_1234);
    chk("alu.rd", ExMe_out_rd, 32'd5);
    chk("alu.ctl", {ExMe_out_reg_wrt, ExMe_out_valid, ExMe_out_mem_en, stall}, 32'b1100);

    // Load with two stall cycles, done in the third cycle
    setEx(32'h0000_0100, 32'h0, 0, 1, 1, 1, 5'd7, 1);
    step();
    setEx(32'h0000_0200, 32'h0, 0, 0, 1, 0, 5'd8, 1);
    chk("ld.c1", {ExMe_out_mem_en, ExMe_out_mem_wrt, stall, ExMe_out_mem_to_reg}, 32'b1011);
    step();
    chk("ld.c2", {ExMe_out_mem_en, stall}, 32'b01);
    chk("ld.c2.alu", ExMe_out_alu_out, 32'h0000_0100);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("hold.flush", {ExMe_out_valid, ExMe_out_reg_wrt, ExMe_out_mem_to_reg}, 32'b111);
    chk("hold.rd", ExMe_out_rd, 32'd7);
    mem_done = 1'b1;
    #1;
    chk("ld.done.stall", stall, 32'd0);
    chk("ld.cnt", stall_cnt, 32'd2);
    step();
    mem_done = 1'b0;
    chk("ld.next", ExMe_out_alu_out, 32'h0000_0200);
    chk("ld.next.rd", ExMe_out_rd, 32'd8);
    chk("ld.next.ctl", {ExMe_out_mem_en, stall}, 32'b00);

    // Zero-wait store followed back-to-back by a load
    setEx(32'h0000_0300, 32'h0000_DEAD, 1, 1, 0, 0, 5'd0, 1);
    step();
    chk("st.c1", {ExMe_out_mem_en, ExMe_out_mem_wrt}, 32'b11);
    chk("st.data", ExMe_out_reg_2, 32'h0000_DEAD);
    setEx(32'h0000_0400, 32'h0, 0, 1, 1, 1, 5'd9, 1);
    mem_done = 1'b1;
    #1;
    chk("st.stall", stall, 32'd0);
    step();
    chk("b2b.alu", ExMe_out_alu_out, 32'h0000_0400);
    chk("b2b.ctl", {ExMe_out_mem_en, ExMe_out_mem_wrt, stall}, 32'b100);
    setEx(32'h0000_0500, 32'h0, 0, 0, 1, 0, 5'd10, 1);
    step();
    mem_done = 1'b0;
    #1;
    chk("b2b.after", ExMe_out_alu_out, 32'h0000_0500);
    chk("b2b.idle", {ExMe_out_mem_en, stall}, 32'b00);
    chk("b2b.cnt", stall_cnt, 32'd2);

    // Flush while not stalled, then an invalid bubble
    setEx(32'h0000_0600, 32'h0000_BEEF, 1, 1, 1, 1, 5'd11, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush.ctl", {ExMe_out_valid, ExMe_out_mem_en, ExMe_out_mem_wrt,
                      ExMe_out_reg_wrt, ExMe_out_mem_to_reg, stall}, 32'd0);
    chk("flush.alu", ExMe_out_alu_out, 32'd0);
    setEx(32'h0000_0700, 32'h0, 1, 1, 1, 1, 5'd12, 0);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    #1;
    chk("spur.ctl", {ExMe_out_valid, ExMe_out_mem_en, stall}, 32'd0);
    chk("spur.rd", ExMe_out_rd, 32'd0);
    step();
    chk("spur.stall", stall, 32'd0);
    chk("spur.cnt", stall_cnt, 32'd2);

    // Reset mid-WAIT abandons the access; a later done is spurious
    setEx(32'h0000_0800, 32'h0, 0, 1, 1, 1, 5'd13, 1);
    step();
    setEx(32'h0, 32'h0, 0, 0, 0, 0, 5'd0, 0);
    step();
    chk("wait.stall", stall, 32'd1);
    #2 rst_n = 1'b1;
    #1;
    chkAllZero("rstmid");
    #1 rst_n = 1'b0;
    mem_done = 1'b1;
    step();
    chk("postrst.done", {ExMe_out_valid, stall}, 32'd0);
    mem_done = 1'b0;
    #1;
    chk("postrst.stall", stall, 32'd0);

    // Saturation: hold a load with no done for many cycles
    setEx(32'h0000_0900, 32'h0, 0, 1, 1, 1, 5'd14, 1);
    step();
    setEx(32'h0, 32'h0, 0, 0, 0, 0, 5'd0, 0);
    chk("sat.start", stall_cnt, 32'd0);
    repeat (65534) step();
    chk("sat.fffe", stall_cnt, 32'h0000_FFFE);
    repeat (3) step();
    chk("sat.ffff", stall_cnt, 32'h0000_FFFF);
    chk("sat.held", ExMe_out_alu_out, 32'h0000_0900);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    #1;
    chk("sat.end", {stall, ExMe_out_valid}, 32'b00);
    chk("sat.keep", stall_cnt, 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exme_reg.md
EXME_REG -- requirements
Module: exme_reg

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-high.
REQ-002 SHALL have no parameters; all widths are fixed as listed.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous reset; asserted when 1, despite the suffix.
REQ-005 Ex_alu_out  in  32  execute result or memory address.
REQ-006 Ex_reg_2  in  32  store data.
REQ-007 Ex_mem_wrt, Ex_mem_en, Ex_reg_wrt, Ex_mem_to_reg  in  1 each  execute-stage controls.
REQ-008 Ex_rd  in  5  destination register.
REQ-009 Ex_valid  in  1  execute stage holds a real instruction.
REQ-010 flush  in  1  load a bubble instead of the Ex_* inputs.
REQ-011 mem_done  in  1  data-memory access complete; connects to the memory stage done output.
REQ-012 ExMe_out_alu_out, ExMe_out_reg_2  out  32 each  registered data.
REQ-013 ExMe_out_mem_wrt, ExMe_out_reg_wrt, ExMe_out_mem_to_reg  out  1 each  registered controls.
REQ-014 ExMe_out_rd  out  5  registered destination register.
REQ-015 ExMe_out_valid  out  1  register holds a real instruction.
REQ-016 ExMe_out_mem_en  out  1  memory request pulse.
REQ-017 stall  out  1  freezes upstream stages.
REQ-018 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-019 Load: when stall=0, every register SHALL capture its Ex_* input on the clock edge.
- If flush=1 or Ex_valid=0, all control outputs and valid are captured as 0; data fields are captured as 0.
REQ-020 Hold: when stall=1, all data, control and valid registers SHALL hold their values; flush SHALL be ignored.
REQ-021 FSM states SHALL be IDLE and WAIT.
REQ-022 IDLE->WAIT SHALL occur on the edge after a valid instruction with mem_en=1 is loaded and mem_done=0 in its first cycle.
REQ-023 WAIT->IDLE SHALL occur on the edge where mem_done=1.
REQ-024 ExMe_out_mem_en SHALL be high for exactly the first cycle a valid memory instruction occupies the register, and low while in WAIT.
REQ-025 The memory request SHALL be issued exactly once per instruction.
REQ-026 stall SHALL be combinational: 1 when (first cycle of a memory instruction OR state==WAIT) AND mem_done=0; otherwise 0.
REQ-027 mem_done=1 in the same cycle as the request (zero wait) SHALL give stall=0 and keep the FSM in IDLE, so a new instruction loads on that edge.
REQ-028 mem_done while IDLE with no request outstanding SHALL be ignored.
REQ-029 Back-to-back memory instructions SHALL each get one mem_en pulse, with no dead cycle when the first completes with done.
REQ-030 stall_cnt SHALL increment on every edge where stall=1, saturate at 16'hFFFF and never wrap.
REQ-031 ExMe_out_mem_wrt SHALL be forwarded unchanged alongside mem_en and SHALL be 0 for bubbles.

Reset
REQ-032 rst_n=1 SHALL immediately (asynchronously) force:
- all outputs to 0;
- FSM to IDLE;
- stall_cnt to 0.
REQ-033 Reset asserted mid-WAIT SHALL abandon the outstanding access.
REQ-034 A mem_done arriving after reset release SHALL be treated as spurious per REQ-028.
REQ-035 Outputs SHALL become non-zero only via a load edge after reset deasserts.

Verification
REQ-036 Reset: assert rst_n mid-cycle -> all outputs 0 before the next edge; stall_cnt=0.
REQ-037 ALU pass-through: load alu_out=0x0000_1234, rd=5, reg_wrt=1, mem_en=0 -> one edge later outputs match, stall=0, mem_en=0.
REQ-038 Load with 3-cycle latency: load mem_en=1, mem_wrt=0, then mem_done=1 two cycles later.
- mem_en pulses 1 cycle; stall=1 for 2 cycles; stall_cnt=2.
- The next instruction loads on the done edge.
REQ-039 Zero-wait store: mem_en=1, mem_wrt=1, mem_done=1 in the first cycle -> stall never 1; FSM stays IDLE; mem_en 1 cycle.
REQ-040 Flush and hold:
- flush=1 while stall=0 -> valid=0 and all controls 0.
- flush=1 during WAIT -> ignored; held instruction intact.
REQ-041 Spurious done and saturation:
- mem_done=1 while IDLE and empty -> no state change.
- preload stall_cnt to 0xFFFE, stall 3 cycles -> stall_cnt=0xFFFF.
